fp_norm_ctrl: RTL

Multi-cycle mantissa normalisation controller for the floating-point datapath. It accepts an unnormalised mantissa/exponent pair, finds the leading one with one byte-wide `Encoder8to3` lookup per cycle, then left-shifts the mantissa and adjusts the exponent in a single cycle. It flags zero and underflow results. It sits after the add/sub mantissa stage and before rounding, with valid/ready handshakes on both sides.

---
 rtl/fp_norm_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fp_norm_ctrl.sv
// Multi-cycle mantissa normaliser: byte-serial leading-one scan followed by a
// single-cycle left shift with exponent adjust, zero and underflow flags.

module Encoder8to3 (
  input  logic [7:0] in,
  input  logic       en,
  output logic [2:0] out,
  output logic       no1
);
  // Plain OR encoder: only meaningful for a one-hot input.
  assign out[0] = en & (in[1] | in[3] | in[5] | in[7]);
  assign out[1] = en & (in[2] | in[3] | in[6] | in[7]);
  assign out[2] = en & (in[4] | in[5] | in[6] | in[7]);
  assign no1    = ~en | (in == 8'd0);
endmodule

module fp_norm_ctrl #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow,
  output logic              busy
);
  localparam int NB    = MANT_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int LZ_W  = $clog2(MANT_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [MANT_W-1:0] m_reg;
  logic [EXP_W-1:0]  e_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [LZ_W-1:0]   lz_reg;

  logic [7:0]        byte_sel;
  logic [7:0]        mask;
  logic [2:0]        enc_out;
  logic              enc_no1;
  logic [LZ_W-1:0]   lz_next;
  logic [EXP_W-1:0]  lz_ext;

  assign byte_sel = m_reg[{idx_reg, 3'b000} +: 8];

  // Keep only the highest set bit so the OR encoder sees a one-hot word.
  assign mask[7] = byte_sel[7];
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_iso
      assign mask[gi] = byte_sel[gi] & ~(|byte_sel[7:gi+1]);
    end
  endgenerate

  Encoder8to3 u_enc (
    .in  (mask),
    .en  (1'b1),
    .out (enc_out),
    .no1 (enc_no1)
  );

  assign lz_next = ((LZ_W'(NB - 1) - LZ_W'(idx_reg)) << 3) + LZ_W'(3'd7 - enc_out);
  assign lz_ext  = EXP_W'(lz_reg);

  assign in_ready  = (state_reg == IDLE) & ~rst;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      e_reg     <= '0;
      idx_reg   <= '0;
      lz_reg    <= '0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            m_reg     <= in_mant;
            e_reg     <= in_exp;
            idx_reg   <= IDX_W'(NB - 1);
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (!enc_no1) begin
            lz_reg    <= lz_next;
            state_reg <= SHIFT;
          end else if (idx_reg == '0) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        SHIFT: begin
          // When the exponent cannot absorb the shift, stop at exponent 0.
          if (lz_ext < e_reg) begin
            out_mant  <= m_reg << lz_reg;
            out_exp   <= e_reg - lz_ext;
            out_uflow <= 1'b0;
          end else begin
            out_mant  <= m_reg << e_reg;
            out_exp   <= '0;
            out_uflow <= 1'b1;
          end
          state_reg <= DONE;
        end
        default: begin
          if (out_ready) state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule
